// File: rtl/mem_bus_arbiter.sv
// Shares one single-ported memory bus between the instruction-fetch path
// and the data-access path. The arbiter runs one registered bus transaction
// at a time and returns read data with a single-cycle ack. A busy-cycle
// timeout aborts a hung transaction and pulses err_o. A run counter stops
// back-to-back data accesses from starving instruction fetch.
`timescale 1ns/1ps
module mem_bus_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 15,
  parameter int MAX_MEM_RUN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_ack_o,
  output logic              bus_cyc_o,
  output logic              bus_stb_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              stallreq_o,
  output logic              err_o
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;

  localparam int               RUN_W   = (MAX_MEM_RUN < 1) ? 1 : $clog2(MAX_MEM_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_MEM_RUN);
  // The abort fires on the edge that ends the TIMEOUT-th busy cycle without an ack.
  localparam logic [7:0]       TO_LAST = 8'(TIMEOUT - 1);

  state_t           state, state_next;
  logic [7:0]       to_cnt;
  logic [RUN_W-1:0] run_cnt;
  logic             grant_mem, grant_if, done, abort;

  // Next-state decode: grant selection in IDLE, completion/timeout in BUSY
  always_comb begin
    state_next = state;
    grant_mem  = 1'b0;
    grant_if   = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req_i && (!if_req_i || (run_cnt < RUN_MAX))) begin
          grant_mem  = 1'b1;
          state_next = MEM_BUSY;
        end else if (if_req_i) begin
          grant_if   = 1'b1;
          state_next = IF_BUSY;
        end
      end
      IF_BUSY, MEM_BUSY: begin
        // An ack in the threshold cycle still completes normally
        if (bus_ack_i) begin
          done       = 1'b1;
          state_next = IDLE;
        end else if (to_cnt == TO_LAST) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Bus drive, ack/err pulses, returned data, timeout and MEM-run counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_cyc_o   <= 1'b0;
      bus_stb_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      if_ack_o    <= 1'b0;
      mem_ack_o   <= 1'b0;
      err_o       <= 1'b0;
      if_rdata_o  <= '0;
      mem_rdata_o <= '0;
      to_cnt      <= '0;
      run_cnt     <= '0;
    end else begin
      if_ack_o  <= 1'b0;
      mem_ack_o <= 1'b0;
      err_o     <= 1'b0;
      if (grant_mem) begin
        bus_cyc_o   <= 1'b1;
        bus_stb_o   <= 1'b1;
        bus_we_o    <= mem_we_i;
        bus_sel_o   <= mem_sel_i;
        bus_addr_o  <= mem_addr_i;
        bus_wdata_o <= mem_wdata_i;
        // Only a grant taken while IF is waiting counts toward the run
        run_cnt     <= if_req_i ? run_cnt + 1'b1 : '0;
      end else if (grant_if) begin
        bus_cyc_o   <= 1'b1;
        bus_stb_o   <= 1'b1;
        bus_we_o    <= 1'b0;
        bus_sel_o   <= 4'hF;
        bus_addr_o  <= if_addr_i;
        bus_wdata_o <= '0;
        run_cnt     <= '0;
      end
      if (done || abort) begin
        bus_cyc_o <= 1'b0;
        bus_stb_o <= 1'b0;
        to_cnt    <= '0;
        err_o     <= abort;
        if (state == IF_BUSY) begin
          if_ack_o   <= 1'b1;
          if_rdata_o <= abort ? '0 : bus_rdata_i;
        end else begin
          mem_ack_o <= 1'b1;
          if (abort)          mem_rdata_o <= '0;
          else if (!bus_we_o) mem_rdata_o <= bus_rdata_i;
        end
      end else if (state != IDLE) begin
        to_cnt <= to_cnt + 8'd1;
      end
    end
  end

  assign stallreq_o = ~rst & ((if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed stimulus pushes expected bus
// cycles and responses into queues; a bus-slave/grant monitor and an ack
// monitor pop and compare as the DUT presents them.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req_i, mem_req_i, mem_we_i;
  logic [31:0] if_addr_i, mem_addr_i, mem_wdata_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] if_rdata_o, mem_rdata_o, bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic        if_ack_o, mem_ack_o, bus_cyc_o, bus_stb_o, bus_we_o, bus_ack_i;
  logic [3:0]  bus_sel_o;
  logic        stallreq_o, err_o;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15), .MAX_MEM_RUN(2)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i),
    .bus_ack_i(bus_ack_i), .stallreq_o(stallreq_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [3:0] sel; logic [31:0] addr; logic [31:0] wdata; } bus_exp_t;
  typedef struct { logic is_mem; logic [31:0] rdata; logic err; } rsp_t;
  typedef struct { int delay; logic [31:0] data; } slv_t;

  bus_exp_t bus_q[$];
  rsp_t     rsp_q[$];
  slv_t     slv_q[$];
  int       checks = 0;
  int       errors = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_bus(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                         input logic [31:0] wdata);
    bus_exp_t e;
    e.we = we; e.sel = sel; e.addr = addr; e.wdata = wdata;
    bus_q.push_back(e);
  endtask

  task automatic exp_rsp(input logic is_mem, input logic [31:0] rdata, input logic err);
    rsp_t r;
    r.is_mem = is_mem; r.rdata = rdata; r.err = err;
    rsp_q.push_back(r);
  endtask

  // delay = busy-cycle index (0-based) carrying bus_ack_i; -1 never acks
  task automatic slave(input int delay, input logic [31:0] data);
    slv_t s;
    s.delay = delay; s.data = data;
    slv_q.push_back(s);
  endtask

  // Bus slave and grant monitor
  initial begin : slave_mon
    int       cnt;
    slv_t     cur;
    bus_exp_t e;
    logic [68:0] snap;
    cnt = 0; cur.delay = -1; cur.data = '0; snap = '0;
    bus_ack_i = 1'b0; bus_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (bus_cyc_o && bus_stb_o) begin
        if (cnt == 0) begin
          snap = {bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o};
          if (slv_q.size() > 0) cur = slv_q.pop_front();
          else begin cur.delay = -1; cur.data = '0; end
          if (bus_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL grant: unexpected bus cycle at addr %0h", bus_addr_o);
          end else begin
            e = bus_q.pop_front();
            check("grant_we",    bus_we_o,    e.we);
            check("grant_sel",   bus_sel_o,   e.sel);
            check("grant_addr",  bus_addr_o,  e.addr);
            check("grant_wdata", bus_wdata_o, e.wdata);
          end
        end else begin
          check("bus_stable", {bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o}, snap);
        end
        bus_ack_i   = (cur.delay == cnt);
        bus_rdata_i = (cur.delay == cnt) ? cur.data : 32'h0;
        cnt++;
      end else begin
        cnt = 0; bus_ack_i = 1'b0; bus_rdata_i = '0;
      end
    end
  end

  // Response monitor
  initial begin : rsp_mon
    rsp_t r;
    forever begin
      @(negedge clk);
      if (if_ack_o || mem_ack_o) begin
        check("ack_exclusive", if_ack_o & mem_ack_o, 1'b0);
        if (rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL ack: unexpected ack if=%0b mem=%0b", if_ack_o, mem_ack_o);
        end else begin
          r = rsp_q.pop_front();
          check("ack_owner", mem_ack_o, r.is_mem);
          check("ack_err",   err_o,     r.err);
          if (r.is_mem) check("mem_rdata", mem_rdata_o, r.rdata);
          else          check("if_rdata",  if_rdata_o,  r.rdata);
        end
      end else if (err_o) begin
        checks++; errors++;
        $display("FAIL err_alone: got err_o=1 expected 0 without an ack");
      end
    end
  end

  // Advance one cycle; a requester drops its request on seeing its ack
  task automatic step();
    @(negedge clk);
    if (if_ack_o)  if_req_i  = 1'b0;
    if (mem_ack_o) mem_req_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max);
    int n;
    n = 0;
    while ((if_req_i || mem_req_i) && n < max) begin step(); n++; end
    if (if_req_i || mem_req_i) begin
      checks++; errors++;
      $display("FAIL %s: no ack within %0d cycles", name, max);
      if_req_i = 1'b0; mem_req_i = 1'b0;
    end
    step();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1);
  end

  initial begin : stim
    int n;
    logic [5:0] pat;
    if_req_i = 0; mem_req_i = 0; mem_we_i = 0; mem_sel_i = 0;
    if_addr_i = 0; mem_addr_i = 0; mem_wdata_i = 0;

    // Reset state
    #1;
    if_req_i = 1'b1;
    #1;
    check("rst_cyc", bus_cyc_o, 0);   check("rst_stb", bus_stb_o, 0);
    check("rst_acks", {if_ack_o, mem_ack_o, err_o}, 0);
    check("rst_rdata", {if_rdata_o, mem_rdata_o}, 0);
    check("rst_bus", {bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o}, 0);
    check("rst_stall", stallreq_o, 0);
    if_req_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step();

    // Single IF read with cycle-exact timing
    exp_bus(0, 4'hF, 32'h100, 0); slave(0, 32'h3401_1100); exp_rsp(0, 32'h3401_1100, 0);
    if_addr_i = 32'h100; if_req_i = 1'b1;
    #1 check("t1_stall_n", stallreq_o, 1);
    @(negedge clk);
    check("t1_addr_n1", bus_addr_o, 32'h100);
    check("t1_cyc_n1", bus_cyc_o, 1);
    check("t1_stall_n1", stallreq_o, 1);
    @(negedge clk);
    check("t1_ack_n2", if_ack_o, 1);
    check("t1_stall_n2", stallreq_o, 0);
    if_req_i = 1'b0;
    step();

    // Simultaneous requests: MEM write first, then IF; write leaves mem_rdata_o at 0
    exp_bus(1, 4'b0011, 32'h200, 32'hDEAD_BEEF); slave(0, 32'h5555_5555); exp_rsp(1, 32'h0, 0);
    exp_bus(0, 4'hF, 32'h104, 0);                slave(0, 32'h1111_2222); exp_rsp(0, 32'h1111_2222, 0);
    mem_we_i = 1; mem_sel_i = 4'b0011; mem_addr_i = 32'h200; mem_wdata_i = 32'hDEAD_BEEF;
    if_addr_i = 32'h104;
    mem_req_i = 1; if_req_i = 1;
    wait_done("t2_simul", 40);

    // Starvation guard: MEM, MEM, IF, MEM, MEM, IF
    pat = 6'b011011;
    mem_we_i = 0; mem_sel_i = 4'hF; mem_addr_i = 32'h300; mem_wdata_i = 0; if_addr_i = 32'h400;
    for (int k = 0; k < 6; k++) begin
      if (pat[k]) exp_bus(0, 4'hF, 32'h300, 0);
      else        exp_bus(0, 4'hF, 32'h400, 0);
      slave(0, 32'hA000_0000 + 32'(k));
      exp_rsp(pat[k], 32'hA000_0000 + 32'(k), 0);
    end
    mem_req_i = 1; if_req_i = 1;
    n = 0;
    for (int c = 0; c < 100 && n < 6; c++) begin
      @(negedge clk);
      if (if_ack_o || mem_ack_o) n++;
    end
    mem_req_i = 0; if_req_i = 0;
    check("t3_ack_count", n, 6);
    step();

    // Timeout: MEM read never acked
    exp_bus(0, 4'hF, 32'h500, 0); slave(-1, 0); exp_rsp(1, 32'h0, 1);
    mem_addr_i = 32'h500; mem_req_i = 1;
    n = 0;
    while (!mem_ack_o && n < 40) begin @(negedge clk); n++; end
    check("t4_latency", n, 16);
    check("t4_cyc_drop", bus_cyc_o, 0);
    mem_req_i = 0;
    step();
    exp_bus(0, 4'hF, 32'h600, 0); slave(0, 32'hCAFE_0001); exp_rsp(0, 32'hCAFE_0001, 0);
    if_addr_i = 32'h600; if_req_i = 1;
    wait_done("t4_if_after", 20);

    // Ack exactly at the threshold cycle: normal completion
    exp_bus(0, 4'hF, 32'h700, 0); slave(14, 32'h1234_5678); exp_rsp(1, 32'h1234_5678, 0);
    mem_addr_i = 32'h700; mem_req_i = 1;
    n = 0;
    while (!mem_ack_o && n < 40) begin @(negedge clk); n++; end
    check("t5_latency", n, 16);
    mem_req_i = 0;
    step();

    // Reset in the middle of an IF transaction
    exp_bus(0, 4'hF, 32'h800, 0); slave(-1, 0);
    if_addr_i = 32'h800; if_req_i = 1;
    repeat (3) @(negedge clk);
    check("t6_cyc_busy", bus_cyc_o, 1);
    exp_bus(0, 4'hF, 32'h800, 0); slave(0, 32'h0BAD_F00D); exp_rsp(0, 32'h0BAD_F00D, 0);
    #2 rst = 1'b1;
    #1;
    check("t6_cyc_async", bus_cyc_o, 0);
    check("t6_stb_async", bus_stb_o, 0);
    check("t6_stall_rst", stallreq_o, 0);
    check("t6_mem_rdata_rst", mem_rdata_o, 0);
    @(posedge clk);
    #1 check("t6_no_ack", if_ack_o, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_done("t6_regrant", 20);

    repeat (3) step();
    check("end_bus_q", bus_q.size(), 0);
    check("end_rsp_q", rsp_q.size(), 0);
    check("end_slv_q", slv_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
